// File: rtl/alu_seq_if.sv
// Operand/opcode request bundle and registered result/status outputs of alu_seq.
interface alu_seq_if #(
  parameter int size = 16
);
  logic            start;
  logic [size-1:0] A;
  logic [size-1:0] B;
  logic [3:0]      control;
  logic            busy;
  logic            done;
  logic [size-1:0] res;
  logic [3:0]      flags;
  logic [2:0]      rgb;

  modport master (output start, A, B, control, input busy, done, res, flags, rgb);
  modport slave  (input start, A, B, control, output busy, done, res, flags, rgb);
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: add/sub/and/or in one cycle, shift-add MUL and restoring DIV in size cycles.
// start is only sampled while idle; res/flags hold between done pulses; rgb is PWM-dimmed op colour.
module alu_seq #(
  parameter int size     = 16,
  parameter int PWM_BITS = 8,
  parameter int BRIGHT   = 64
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b1100;
  localparam int CW = $clog2(size);
  localparam logic [CW-1:0] LAST = CW'(size - 1);
  localparam logic [PWM_BITS:0] BRIGHT_W = (PWM_BITS + 1)'(BRIGHT);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*size-1:0]   prod_q, prod_d, mcand_q, mcand_d;
  logic [size-1:0]     mplier_q, mplier_d;
  logic [size-1:0]     rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [size-1:0]     res_q, res_d;
  logic [3:0]          flags_q, flags_d;
  logic [2:0]          col_q, col_d;
  logic                done_q, done_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;

  logic [2*size-1:0] prod_nx;
  logic [size:0]     sum, rem_sh, trial;
  logic [size-1:0]   rem_nx, quo_nx;
  logic              fin, fin_n, fin_c, fin_e;
  logic [size-1:0]   fin_res;
  logic [2:0]        fin_col;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    res_d    = res_q;
    flags_d  = flags_q;
    col_d    = col_q;
    done_d   = 1'b0;
    pwm_d    = pwm_q + 1'b1;
    fin      = 1'b0;
    fin_n    = 1'b0;
    fin_c    = 1'b0;
    fin_e    = 1'b0;
    fin_res  = '0;
    fin_col  = 3'b000;

    prod_nx = mplier_q[0] ? prod_q + mcand_q : prod_q;
    sum     = {1'b0, bus.A} + {1'b0, bus.B};
    // Restoring step: a borrow out of the trial subtraction means the quotient bit is 0.
    rem_sh  = {rem_q, quo_q[size-1]};
    trial   = rem_sh - {1'b0, dvsr_q};
    rem_nx  = trial[size] ? rem_sh[size-1:0] : trial[size-1:0];
    quo_nx  = {quo_q[size-2:0], ~trial[size]};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.control)
            OP_ADD: begin
              fin = 1'b1; fin_res = sum[size-1:0]; fin_c = sum[size]; fin_col = 3'b001;
            end
            OP_SUB: begin
              fin = 1'b1; fin_col = 3'b010;
              if (bus.B > bus.A) begin
                fin_res = bus.B - bus.A; fin_n = 1'b1; fin_c = 1'b1;
              end else begin
                fin_res = bus.A - bus.B;
              end
            end
            OP_MUL: begin
              state_d  = S_MUL;
              cnt_d    = '0;
              prod_d   = '0;
              mcand_d  = {{size{1'b0}}, bus.A};
              mplier_d = bus.B;
            end
            OP_DIV: begin
              if (bus.B == '0) begin
                fin = 1'b1; fin_res = '1; fin_e = 1'b1; fin_col = 3'b111;
              end else begin
                state_d = S_DIV;
                cnt_d   = '0;
                rem_d   = '0;
                quo_d   = bus.A;
                dvsr_d  = bus.B;
              end
            end
            OP_AND: begin
              fin = 1'b1; fin_res = bus.A & bus.B; fin_col = 3'b100;
            end
            OP_OR: begin
              fin = 1'b1; fin_res = bus.A | bus.B; fin_col = 3'b101;
            end
            default: begin
              fin = 1'b1; fin_e = 1'b1; fin_col = 3'b111;
            end
          endcase
        end
      end
      S_MUL: begin
        prod_d   = prod_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          fin = 1'b1; fin_res = prod_nx[size-1:0]; fin_c = |prod_nx[2*size-1:size];
          fin_col = 3'b011;
        end
      end
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          fin = 1'b1; fin_res = quo_nx; fin_col = 3'b110;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      res_d   = fin_res;
      flags_d = {fin_n, (fin_res == '0), fin_c, fin_e};
      col_d   = fin_col;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      col_q    <= '0;
      done_q   <= 1'b0;
      pwm_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      col_q    <= col_d;
      done_q   <= done_d;
      pwm_q    <= pwm_d;
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = done_q;
  assign bus.res   = res_q;
  assign bus.flags = flags_q;
  assign bus.rgb   = col_q & {3{({1'b0, pwm_q} < BRIGHT_W)}};
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, hand-written multi-cycle sequences, random ops vs a model.
module tb_alu_seq;
  localparam int SZ = 16;
  localparam logic [3:0] ADD = 4'b1000, SUB = 4'b0100, MUL = 4'b0010,
                         DIV = 4'b0011, AND = 4'b0001, ORR = 4'b1100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.size(SZ)) bus ();
  alu_seq_if #(.size(SZ)) bus_z ();

  alu_seq #(.size(SZ), .PWM_BITS(8), .BRIGHT(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  alu_seq #(.size(SZ), .PWM_BITS(8), .BRIGHT(0))  dut_z (.clk(clk), .rst(rst), .bus(bus_z));

  assign bus_z.start   = bus.start;
  assign bus_z.A       = bus.A;
  assign bus_z.B       = bus.B;
  assign bus_z.control = bus.control;

  int checks = 0;
  int errors = 0;
  int edges;
  int z_bad = 0;

  // Free-running count of clock edges since reset, mirroring the PWM period.
  always @(posedge clk or posedge rst)
    if (rst) edges <= 0;
    else     edges <= edges + 1;

  always @(negedge clk)
    if (bus_z.rgb !== 3'b000) z_bad++;

  typedef struct {
    logic [3:0]    op;
    logic [SZ-1:0] a, b, r;
    logic [3:0]    f;
    logic [2:0]    col;
    int            lat;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_rgb(input logic [2:0] col);
    return ((edges % 256) < 64) ? col : 3'b000;
  endfunction

  function automatic void model(input logic [3:0] op, input logic [SZ-1:0] a, input logic [SZ-1:0] b,
                                output logic [SZ-1:0] r, output logic [3:0] f,
                                output logic [2:0] col, output int lat);
    logic [31:0] full;
    logic n, c, e;
    n = 0; c = 0; e = 0; lat = 0; r = '0; col = 3'b111;
    case (op)
      ADD: begin full = 32'(a) + 32'(b); r = full[15:0]; c = (full > 32'hFFFF); col = 3'b001; end
      SUB: begin
        col = 3'b010;
        if (b > a) begin r = b - a; n = 1; c = 1; end
        else r = a - b;
      end
      MUL: begin full = 32'(a) * 32'(b); r = full[15:0]; c = (full / 65536) != 0; col = 3'b011; lat = SZ; end
      DIV: begin
        if (b == 0) begin r = 16'hFFFF; e = 1; col = 3'b111; end
        else begin r = a / b; col = 3'b110; lat = SZ; end
      end
      AND: begin r = a & b; col = 3'b100; end
      ORR: begin r = a | b; col = 3'b101; end
      default: begin r = '0; e = 1; col = 3'b111; end
    endcase
    f = {n, (r == 0), c, e};
  endfunction

  // Issue one op and check it through to its done pulse; optionally pulse an ADD start mid-flight.
  task automatic run_op(input string name, input logic [3:0] op, input logic [SZ-1:0] a,
                        input logic [SZ-1:0] b, input logic [SZ-1:0] er, input logic [3:0] ef,
                        input logic [2:0] ecol, input int lat, input bit inject);
    logic [SZ-1:0] prev;
    int bad;
    prev = bus.res;
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.control = op;
    tick();
    bus.start = 1'b0;
    if (lat > 0) begin
      check({name, "_busy_on"}, 32'(bus.busy), 32'd1);
      bad = (bus.done !== 1'b0 || bus.res !== prev) ? 1 : 0;
      for (int i = 1; i < lat; i++) begin
        if (inject && i == 5) begin
          bus.start = 1'b1; bus.control = ADD; bus.A = 16'd1; bus.B = 16'd1;
        end else begin
          bus.start = 1'b0;
        end
        tick();
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.res !== prev) bad++;
      end
      bus.start = 1'b0;
      check({name, "_quiet_while_busy"}, 32'(bad), 32'd0);
      tick();
      check({name, "_busy_off"}, 32'(bus.busy), 32'd0);
    end
    check({name, "_done"}, 32'(bus.done), 32'd1);
    check({name, "_res"}, 32'(bus.res), 32'(er));
    check({name, "_flags"}, 32'(bus.flags), 32'(ef));
    check({name, "_rgb"}, 32'(bus.rgb), 32'(exp_rgb(ecol)));
  endtask

  initial begin
    logic [SZ-1:0] r, a, b;
    logic [3:0] f, op;
    logic [2:0] col;
    int lat, bad, n101, n000;

    vt[0] = '{ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 3'b001, 0};
    vt[1] = '{SUB, 16'd3,    16'd5,    16'd2,    4'b1010, 3'b010, 0};
    vt[2] = '{SUB, 16'd5,    16'd5,    16'd0,    4'b0100, 3'b010, 0};
    vt[3] = '{MUL, 16'd300,  16'd300,  16'h5F90, 4'b0010, 3'b011, 16};
    vt[4] = '{DIV, 16'd100,  16'd7,    16'd14,   4'b0000, 3'b110, 16};
    vt[5] = '{DIV, 16'd9,    16'd0,    16'hFFFF, 4'b0001, 3'b111, 0};
    vt[6] = '{AND, 16'hF0F0, 16'h0F0F, 16'h0000, 4'b0100, 3'b100, 0};
    vt[7] = '{ORR, 16'h00F0, 16'h0F01, 16'h0FF1, 4'b0000, 3'b101, 0};
    vt[8] = '{4'b0000, 16'h1234, 16'h5678, 16'h0000, 4'b0101, 3'b111, 0};

    rst = 1'b1;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.control = '0;
    #3;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_res", 32'(bus.res), 32'd0);
    check("reset_flags", 32'(bus.flags), 32'd0);
    check("reset_rgb", 32'(bus.rgb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_no_done", 32'(bus.done), 32'd0);

    foreach (vt[i])
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].r, vt[i].f, vt[i].col,
             vt[i].lat, 1'b0);

    // Back-to-back SUBs: two consecutive done pulses.
    run_op("sub_b2b_a", SUB, 16'd3, 16'd5, 16'd2, 4'b1010, 3'b010, 0, 1'b0);
    run_op("sub_b2b_b", SUB, 16'd5, 16'd5, 16'd0, 4'b0100, 3'b010, 0, 1'b0);
    tick();
    check("sub_b2b_done_drop", 32'(bus.done), 32'd0);

    // MUL with an ADD start pulsed mid-operation: ignored, no extra done.
    run_op("mul_inject", MUL, 16'd300, 16'd300, 16'h5F90, 4'b0010, 3'b011, 16, 1'b1);
    tick();
    check("mul_inject_no_extra_done", 32'(bus.done), 32'd0);
    check("mul_inject_res_held", 32'(bus.res), 32'h5F90);

    // PWM duty over two full periods after an OR.
    run_op("pwm_or", ORR, 16'h00FF, 16'h0F00, 16'h0FFF, 4'b0000, 3'b101, 0, 1'b0);
    n101 = 0; n000 = 0; bad = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (bus.rgb === 3'b101) n101++;
      else if (bus.rgb === 3'b000) n000++;
      else bad++;
    end
    check("pwm_on_cycles", 32'(n101), 32'd128);
    check("pwm_off_cycles", 32'(n000), 32'd384);
    check("pwm_other_values", 32'(bad), 32'd0);

    // Reset at cycle 5 of a MUL.
    tick();
    bus.start = 1'b1; bus.A = 16'd300; bus.B = 16'd300; bus.control = MUL;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #1 rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_res", 32'(bus.res), 32'd0);
    check("rst_mid_flags", 32'(bus.flags), 32'd0);
    check("rst_mid_rgb", 32'(bus.rgb), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("rst_mid_no_done_after", 32'(bad), 32'd0);
    run_op("and_after_rst", AND, 16'hF0F0, 16'h0F0F, 16'h0000, 4'b0100, 3'b100, 0, 1'b0);

    // Randomized ops against the arithmetic model.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 6))
        0: op = ADD; 1: op = SUB; 2: op = MUL; 3: op = DIV;
        4: op = AND; 5: op = ORR; default: op = 4'($urandom_range(0, 15));
      endcase
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'd0;
        1: b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      model(op, a, b, r, f, col, lat);
      run_op($sformatf("rand%0d", k), op, a, b, r, f, col, lat, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) tick();
    end

    check("bright0_rgb_never_on", 32'(z_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
